lsu_bus_master: RTL
===================

Name: lsu_bus_master

Overview:
- Initiator side of the data-memory and timer bus in the pipelined MIPS core.
- Accepts one load/store request at a time from the M stage and checks it for address and alignment exceptions.
- Drives a registered req/ack bus transaction toward data memory or the timer devices.
- Returns aligned, sign- or zero-extended load data, or an exception code, to the pipeline.

Parameters:
- DM_TOP, 32'h00002fff, highest byte address served by data memory.
- TIMEOUT, 15, bus_ack wait cycles before a bus-error response (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  M-stage request valid.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_op  in  3  operation: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and exceptions.
- rsp_exc  out  1  exception flag.
- rsp_exccode  out  5  4 = AdEL, 5 = AdES, 0 = none.
- busy  out  1  transaction in flight; pipeline stall.
- bus_req  out  1  bus request.
- bus_we  out  1  write strobe.
- bus_addr  out  32  word address, {addr[31:2], 2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-shifted write data.
- bus_ack  in  1  responder completion.
- bus_rdata  in  32  responder read word, valid with bus_ack.

Behaviour:
- Reset (async, reset==0): state IDLE; every output 0 except req_ready = 1; latched request cleared. Reset mid-transaction drops bus_req immediately and emits no response.
- FSM states:
  - IDLE: req_ready = 1. On req_valid, latch op, addr, wdata, evaluate exceptions, go to ISSUE (no exception) or EXC.
  - ISSUE/WAIT: bus_req = 1 with address, data and enables held stable. Stay until bus_ack is sampled, then capture bus_rdata and go to RESP.
  - RESP: rsp_valid = 1 for one cycle, then IDLE.
  - EXC: rsp_valid = 1, rsp_exc = 1, no bus activity, then IDLE.
- Latency: request accepted at edge N; bus_req high from N+1; ack at edge M gives rsp_valid during cycle M+1. Minimum 3 cycles accept-to-response; exception path 1 cycle after accept.
- busy = 1 in every state except IDLE. req_ready = 0 outside IDLE. A new request can be accepted in the cycle after rsp_valid.
- Address classes:
  - DM: addr <= DM_TOP.
  - TIMER: 0x7f00..0x7f0b or 0x7f10..0x7f1b.
- Exceptions (AdEL for loads, AdES for stores):
  - lw/sw with addr[1:0] != 0.
  - lh/lhu/sh with addr[0] != 0.
  - Address in neither DM nor TIMER.
  - Sub-word access (lh, lhu, lb, lbu, sh, sb) to TIMER.
  - Store to 0x7f08 or 0x7f18 (count registers).
- Byte enables: word 1111; half 0011 or 1100 by addr[1]; byte 0001 << addr[1:0]. bus_be is 0000 for loads.
- Write data: byte replicated to all four lanes; half replicated to both halves; word as-is.
- Load extraction: select the lane by addr[1:0] (byte) or addr[1] (half). lb/lh sign-extend; lbu/lhu zero-extend.
- bus_ack in any state other than ISSUE/WAIT is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- With the macro: a counter starts at bus_req assertion. If TIMEOUT cycles elapse with no bus_ack, bus_req is dropped and a response is issued with rsp_exc = 1 and rsp_exccode = 4 (load) or 5 (store). A late bus_ack after the timeout is ignored.
- Without the macro: no counter; WAIT is held indefinitely.

Test Plan:
- sw 0x12345678 to 0x100 with ack 2 cycles after bus_req -> bus_be = 1111, bus_addr = 0x100, rsp_valid 1 cycle after ack, rsp_exc = 0, busy high throughout.
- lb from 0x103 with bus_rdata = 0x80AA5511 -> rsp_rdata = 0xFFFFFF80. lbu from the same address -> 0x00000080. lhu from 0x102 -> 0x000080AA.
- sb 0xAB to 0x2 -> bus_be = 0100, bus_wdata = 0xABABABAB. sh 0xBEEF to 0x2 -> bus_be = 1100, bus_wdata = 0xBEEFBEEF.
- lw 0x102, sh 0x101, sw 0x7f08, lb 0x7f04, lw 0x3000 -> no bus_req; rsp_exc = 1 with exccode 4, 5, 5, 4, 4 respectively, one cycle after accept.
- reset pulled low while in WAIT -> bus_req = 0 and rsp_valid = 0 immediately, req_ready = 1 after release; a following lw 0x7f00 completes normally.
- With LSU_TIMEOUT_EN, lw 0x200 and bus_ack never asserted -> after 15 cycles rsp_exc = 1, exccode = 4; an ack arriving 2 cycles later produces no second response.

Source files
------------

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: M-stage load/store initiator on the data-memory / timer req-ack bus.
// Optional bus_ack watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_bus_master #(
    parameter logic [31:0] DM_TOP  = 32'h00002fff,
    parameter int          TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_exc,
    output logic [4:0]  rsp_exccode,
    output logic        busy,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2,
        S_EXC  = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0]  op;
        logic        st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } lreq_t;

    state_t      state_q, state_d;
    lreq_t       lreq_q, lreq_d;
    logic [31:0] rdata_q, rdata_d;

    logic        in_st, in_word, in_half, in_dm, in_tmr, in_exc;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;
    logic        tmo;

    function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (op)
            OP_LH:   load_ext = {{16{h[15]}}, h};
            OP_LHU:  load_ext = {16'h0000, h};
            OP_LB:   load_ext = {{24{b[7]}}, b};
            OP_LBU:  load_ext = {24'h000000, b};
            default: load_ext = w;
        endcase
    endfunction

    // Classify the incoming request and prepare lane-shifted store data.
    always_comb begin
        in_st   = (req_op == OP_SW) || (req_op == OP_SH) || (req_op == OP_SB);
        in_word = (req_op == OP_LW) || (req_op == OP_SW);
        in_half = (req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH);
        in_dm   = (req_addr <= DM_TOP);
        in_tmr  = ((req_addr >= 32'h00007f00) && (req_addr <= 32'h00007f0b)) ||
                  ((req_addr >= 32'h00007f10) && (req_addr <= 32'h00007f1b));
        in_exc  = (in_word && (req_addr[1:0] != 2'b00)) ||
                  (in_half && req_addr[0]) ||
                  !(in_dm || in_tmr) ||
                  (in_tmr && !in_word) ||
                  (in_st && ((req_addr == 32'h00007f08) || (req_addr == 32'h00007f18)));
        in_wdata = {4{req_wdata[7:0]}};
        if (in_word)
            in_wdata = req_wdata;
        else if (in_half)
            in_wdata = {2{req_wdata[15:0]}};
        in_be = 4'b0000;
        if (in_st) begin
            if (in_word)
                in_be = 4'b1111;
            else if (in_half)
                in_be = req_addr[1] ? 4'b1100 : 4'b0011;
            else
                in_be = 4'b0001 << req_addr[1:0];
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Counts cycles spent with bus_req high; cleared whenever the bus is idle.
    always_comb begin
        cnt_d = (state_q == S_BUS) ? cnt_q + CW'(1) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tmo = (cnt_q == CW'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            lreq_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            lreq_q  <= lreq_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lreq_d  = lreq_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    lreq_d.op    = req_op;
                    lreq_d.st    = in_st;
                    lreq_d.addr  = req_addr;
                    lreq_d.wdata = in_wdata;
                    lreq_d.be    = in_be;
                    state_d      = in_exc ? S_EXC : S_BUS;
                end
            end
            S_BUS: begin
                if (bus_ack) begin
                    rdata_d = lreq_q.st ? 32'h0 : load_ext(lreq_q.op, lreq_q.addr[1:0], bus_rdata);
                    state_d = S_RESP;
                end else if (tmo) begin
                    state_d = S_EXC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = 1'b0;
        busy        = 1'b0;
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        bus_addr    = 32'h0;
        bus_be      = 4'b0000;
        bus_wdata   = 32'h0;
        rsp_valid   = 1'b0;
        rsp_rdata   = 32'h0;
        rsp_exc     = 1'b0;
        rsp_exccode = 5'd0;
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_BUS: begin
                busy      = 1'b1;
                bus_req   = 1'b1;
                bus_we    = lreq_q.st;
                bus_addr  = {lreq_q.addr[31:2], 2'b00};
                bus_be    = lreq_q.be;
                bus_wdata = lreq_q.wdata;
            end
            S_RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
            end
            default: begin
                busy        = 1'b1;
                rsp_valid   = 1'b1;
                rsp_exc     = 1'b1;
                rsp_exccode = lreq_q.st ? 5'd5 : 5'd4;
            end
        endcase
    end

endmodule
